// File: rtl/common_param.sv
// rtl/common_param.sv - shared opcode constants, FSM encoding and decode helpers
package common_param;

   localparam logic [5:0] R_FORM     = 6'h00;
   localparam logic [5:0] JAL        = 6'h03;
   localparam logic [5:0] JALR       = 6'h09;
   localparam logic [5:0] ALU_IMM_LO = 6'h08;
   localparam logic [5:0] ALU_IMM_HI = 6'h0F;
   localparam logic [5:0] LB         = 6'h20;
   localparam logic [5:0] LH         = 6'h21;
   localparam logic [5:0] LW         = 6'h23;
   localparam logic [5:0] LBU        = 6'h24;
   localparam logic [5:0] LHU        = 6'h25;
   localparam logic [5:0] SB         = 6'h28;
   localparam logic [5:0] SH         = 6'h29;
   localparam logic [5:0] SW         = 6'h2B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   function automatic logic is_mem_op(input logic [5:0] op);
      case (op)
         LB, LH, LW, LBU, LHU, SB, SH, SW: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   function automatic logic is_store_op(input logic [5:0] op);
      case (op)
         SB, SH, SW: return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic is_signed_op(input logic [5:0] op);
      case (op)
         LB, LH:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic size_t op_size(input logic [5:0] op);
      case (op)
         LB, LBU, SB: return SZ_BYTE;
         LH, LHU, SH: return SZ_HALF;
         default:     return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select and sign/zero extension
module load_align
   import common_param::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  size_t       size,
   input  logic        sign,
   output logic [31:0] value
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rdata[{offset, 3'b000} +: 8];
      lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: value = {{24{sign & lane_b[7]}}, lane_b};
         SZ_HALF: value = {{16{sign & lane_h[15]}}, lane_h};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store/write-back unit with bounded memory handshake
module mem_access_unit
   import common_param::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       Ins,
   input  logic [31:0]       Result,
   input  logic [31:0]       Rdata2,
   input  logic [31:0]       nextPC,
   output logic [31:0]       Wdata,
   output logic              out_valid,
   output logic              misalign,
   output logic              timeout,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [5:0]  op, funct;
   logic        acc_mem, acc_mis;
   size_t       acc_size;
   logic [3:0]  acc_be;
   logic [31:0] acc_wdata, alu_wdata;
   logic [1:0]  ld_off;
   size_t       ld_size;
   logic        ld_sign, ld_store;
   logic [31:0] ld_value;
   logic        err_mis, err_to;
   logic        unused_ins;

   assign op         = Ins[31:26];
   assign funct      = Ins[5:0];
   assign unused_ins = ^Ins[25:6];

   always_comb begin
      acc_mem   = is_mem_op(op);
      acc_size  = op_size(op);
      acc_mis   = acc_mem && ((acc_size == SZ_HALF && Result[0]) ||
                              (acc_size == SZ_WORD && Result[1:0] != 2'b00));
      acc_be    = 4'b1111;
      acc_wdata = Rdata2;
      case (acc_size)
         SZ_BYTE: begin
            acc_be    = 4'b0001 << Result[1:0];
            acc_wdata = {4{Rdata2[7:0]}};
         end
         SZ_HALF: begin
            acc_be    = Result[1] ? 4'b1100 : 4'b0011;
            acc_wdata = {2{Rdata2[15:0]}};
         end
         default: ;
      endcase
      if (op == JAL || (op == R_FORM && funct == JALR))
         alu_wdata = nextPC;
      else if (op == R_FORM || (op >= ALU_IMM_LO && op <= ALU_IMM_HI))
         alu_wdata = Result;
      else
         alu_wdata = '0;
   end

   load_align u_load_align (
      .rdata  (mem_rdata),
      .offset (ld_off),
      .size   (ld_size),
      .sign   (ld_sign),
      .value  (ld_value)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = (acc_mem && !acc_mis) ? REQ : DONE;
         end
         REQ: begin
            if (mem_ack || cnt == CNT_LAST) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Flags only exist while DONE presents them.
   assign misalign = out_valid & err_mis;
   assign timeout  = out_valid & err_to;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt       <= '0;
         Wdata     <= '0;
         err_mis   <= 1'b0;
         err_to    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_adr   <= '0;
         mem_wdata <= '0;
         ld_off    <= '0;
         ld_size   <= SZ_BYTE;
         ld_sign   <= 1'b0;
         ld_store  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (in_valid) begin
                  err_mis <= acc_mis;
                  err_to  <= 1'b0;
                  Wdata   <= acc_mem ? '0 : alu_wdata;
                  if (acc_mem && !acc_mis) begin
                     mem_req   <= 1'b1;
                     mem_we    <= is_store_op(op);
                     mem_be    <= acc_be;
                     mem_adr   <= {Result[ADDR_W-1:2], 2'b00};
                     mem_wdata <= acc_wdata;
                     ld_off    <= Result[1:0];
                     ld_size   <= acc_size;
                     ld_sign   <= is_signed_op(op);
                     ld_store  <= is_store_op(op);
                  end
               end
            end
            REQ: begin
               // An ack on the last allowed cycle still counts as a completion.
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  Wdata   <= ld_store ? '0 : ld_value;
               end else if (cnt == CNT_LAST) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  err_to  <= 1'b1;
                  Wdata   <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

   localparam int TMO = 4;

   logic        CLK, RST, in_valid, in_ready;
   logic [31:0] Ins, Result, Rdata2, nextPC, Wdata;
   logic        out_valid, misalign, timeout;
   logic        mem_req, mem_we, mem_ack;
   logic [3:0]  mem_be;
   logic [31:0] mem_adr, mem_wdata, mem_rdata;

   mem_access_unit #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .Ins(Ins), .Result(Result), .Rdata2(Rdata2), .nextPC(nextPC),
      .Wdata(Wdata), .out_valid(out_valid), .misalign(misalign), .timeout(timeout),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_adr(mem_adr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   typedef struct {
      string       nm;
      logic [31:0] wd;
      bit          mis;
      bit          to;
      int          cyc;
   } oexp_t;

   typedef struct {
      string       nm;
      logic [31:0] adr;
      logic [3:0]  be;
      bit          we;
      bit          chk_wd;
      logic [31:0] wd;
      int          len;
   } mexp_t;

   oexp_t oq[$];
   mexp_t mq[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Output monitor: every out_valid pulse must match the oldest expectation.
   always @(negedge CLK) begin
      oexp_t e;
      if (out_valid) begin
         if (oq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid: got 1 expected 0");
         end else begin
            e = oq.pop_front();
            chk({e.nm, "_wdata"}, Wdata, e.wd);
            chk({e.nm, "_misalign"}, {31'b0, misalign}, {31'b0, e.mis});
            chk({e.nm, "_timeout"}, {31'b0, timeout}, {31'b0, e.to});
            chk({e.nm, "_out_cycle"}, cyc, e.cyc);
         end
      end else begin
         chk("flags_without_valid", {30'b0, misalign, timeout}, 32'h0);
      end
   end

   // Memory monitor: request contents, stability and duration.
   mexp_t       mcur;
   int          mlen = 0;
   logic        mprev = 1'b0;
   logic [31:0] sadr, swd;
   logic [3:0]  sbe;
   logic        swe;

   always @(negedge CLK) begin
      if (mem_req && !mprev) begin
         if (mq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_mem_req: got 1 expected 0");
            mcur.nm = "spurious";
            mcur.len = 0;
         end else begin
            mcur = mq.pop_front();
            chk({mcur.nm, "_mem_adr"}, mem_adr, mcur.adr);
            chk({mcur.nm, "_mem_be"}, {28'b0, mem_be}, {28'b0, mcur.be});
            chk({mcur.nm, "_mem_we"}, {31'b0, mem_we}, {31'b0, mcur.we});
            if (mcur.chk_wd) chk({mcur.nm, "_mem_wdata"}, mem_wdata, mcur.wd);
         end
         mlen = 1;
         sadr = mem_adr;
         swd  = mem_wdata;
         sbe  = mem_be;
         swe  = mem_we;
      end else if (mem_req) begin
         mlen++;
         chk({mcur.nm, "_mem_hold"},
             (mem_adr == sadr && mem_wdata == swd && mem_be == sbe && mem_we == swe) ? 32'd1 : 32'd0,
             32'd1);
      end else if (mprev) begin
         chk({mcur.nm, "_req_cycles"}, mlen, mcur.len);
      end
      mprev = mem_req;
   end

   // ack_n < 0: never acknowledge; otherwise ack in the REQ cycle with that index.
   task automatic run(input string nm, input logic [31:0] ins, input logic [31:0] res,
                      input logic [31:0] rd2, input logic [31:0] npc, input logic [31:0] rdata,
                      input int ack_n, input bit is_mem, input logic [31:0] adr,
                      input logic [3:0] be, input bit we, input bit chk_wd,
                      input logic [31:0] mwd, input logic [31:0] wd, input bit mis,
                      input bit to, input int lat);
      oexp_t oe;
      mexp_t me;
      int    n;
      @(negedge CLK);
      Ins = ins; Result = res; Rdata2 = rd2; nextPC = npc; mem_rdata = rdata;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge CLK);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL %s_accept: got in_ready=0 expected 1", nm);
         in_valid = 1'b0;
         return;
      end
      oe.nm = nm; oe.wd = wd; oe.mis = mis; oe.to = to; oe.cyc = cyc + lat;
      oq.push_back(oe);
      if (is_mem) begin
         me.nm = nm; me.adr = adr; me.be = be; me.we = we; me.chk_wd = chk_wd; me.wd = mwd;
         me.len = (ack_n < 0) ? TMO : ack_n + 1;
         mq.push_back(me);
      end
      @(posedge CLK);
      #1 in_valid = 1'b0;
      if (ack_n >= 0) begin
         repeat (ack_n) begin
            @(posedge CLK);
            #1;
         end
         mem_ack = 1'b1;
         @(posedge CLK);
         #1 mem_ack = 1'b0;
      end
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!in_ready && n < 40);
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL %s_complete: got in_ready=0 expected 1", nm);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1);
   end

   initial begin
      mexp_t rme;
      RST = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
      Ins = '0; Result = '0; Rdata2 = '0; nextPC = '0; mem_rdata = '0;
      #7;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
      chk("rst_mem_adr", mem_adr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_wdata", Wdata, 32'd0);
      chk("rst_flags", {30'b0, misalign, timeout}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;

      //   name    ins           res           rd2           npc           rdata         ack mem adr          be       we chk mwd           wdata         mis to lat
      run("add",   32'h0000_0020, 32'h0000_1234, 32'h0,        32'h0,        32'h0,        -1, 0, 32'h0,       4'b0000, 0, 0, 32'h0,        32'h0000_1234, 0, 0, 1);
      run("lb",    32'h8000_0000, 32'h0000_0103, 32'h0,        32'h0,        32'h80FF_0000, 2, 1, 32'h100,     4'b1000, 0, 0, 32'h0,        32'hFFFF_FF80, 0, 0, 4);
      run("sh",    32'hA400_0000, 32'h0000_0202, 32'h0000_ABCD, 32'h0,       32'hFFFF_FFFF, 0, 1, 32'h200,     4'b1100, 1, 1, 32'hABCD_ABCD, 32'h0,        0, 0, 2);
      run("lw_mis",32'h8C00_0000, 32'h0000_0102, 32'h0,        32'h0,        32'h0,        -1, 0, 32'h0,       4'b0000, 0, 0, 32'h0,        32'h0,        1, 0, 1);
      run("lhu_to",32'h9400_0000, 32'h0000_0206, 32'h0,        32'h0,        32'h1234_5678, -1, 1, 32'h204,    4'b1100, 0, 0, 32'h0,        32'h0,        0, 1, 5);
      run("lhu_ack3",32'h9400_0000, 32'h0000_0206, 32'h0,      32'h0,        32'h8765_4321, 3, 1, 32'h204,     4'b1100, 0, 0, 32'h0,        32'h0000_8765, 0, 0, 5);
      run("jal",   32'h0C00_0000, 32'h0000_DEAD, 32'h0,        32'h0000_4008, 32'h0,       -1, 0, 32'h0,       4'b0000, 0, 0, 32'h0,        32'h0000_4008, 0, 0, 1);
      run("jalr",  32'h0000_0009, 32'h0000_1111, 32'h0,        32'h0000_0500, 32'h0,       -1, 0, 32'h0,       4'b0000, 0, 0, 32'h0,        32'h0000_0500, 0, 0, 1);
      run("addi",  32'h2000_0000, 32'h0000_0077, 32'h0,        32'h0000_0044, 32'h0,       -1, 0, 32'h0,       4'b0000, 0, 0, 32'h0,        32'h0000_0077, 0, 0, 1);
      run("beq",   32'h1000_0000, 32'h0000_0099, 32'h0,        32'h0000_0044, 32'h0,       -1, 0, 32'h0,       4'b0000, 0, 0, 32'h0,        32'h0,        0, 0, 1);
      run("lh",    32'h8400_0000, 32'h0000_0102, 32'h0,        32'h0,        32'h8001_0000, 1, 1, 32'h100,     4'b1100, 0, 0, 32'h0,        32'hFFFF_8001, 0, 0, 3);
      run("lbu",   32'h9000_0000, 32'h0000_0101, 32'h0,        32'h0,        32'h0000_F000, 0, 1, 32'h100,     4'b0010, 0, 0, 32'h0,        32'h0000_00F0, 0, 0, 2);
      run("sb",    32'hA000_0000, 32'h0000_0003, 32'h1234_5678, 32'h0,       32'h0,         1, 1, 32'h0,       4'b1000, 1, 1, 32'h7878_7878, 32'h0,        0, 0, 3);
      run("sw",    32'hAC00_0000, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,       32'h0,         2, 1, 32'h10,      4'b1111, 1, 1, 32'hCAFE_F00D, 32'h0,        0, 0, 4);
      run("sh_mis",32'hA400_0000, 32'h0000_0201, 32'h0000_1111, 32'h0,       32'h0,        -1, 0, 32'h0,       4'b0000, 0, 0, 32'h0,        32'h0,        1, 0, 1);
      run("lw",    32'h8C00_0000, 32'h0000_01FC, 32'h0,        32'h0,        32'hDEAD_BEEF, 0, 1, 32'h1FC,     4'b1111, 0, 0, 32'h0,        32'hDEAD_BEEF, 0, 0, 2);

      // Reset in the middle of a pending request.
      @(negedge CLK);
      Ins = 32'h8C00_0000; Result = 32'h0000_0300; in_valid = 1'b1;
      rme.nm = "rst_mid"; rme.adr = 32'h300; rme.be = 4'b1111; rme.we = 1'b0;
      rme.chk_wd = 1'b0; rme.wd = 32'h0; rme.len = 1;
      mq.push_back(rme);
      @(posedge CLK);
      #1 in_valid = 1'b0;
      @(posedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("rst_mid_mem_req_async", {31'b0, mem_req}, 32'd0);
      chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      repeat (4) @(negedge CLK);
      chk("rst_mid_in_ready_after", {31'b0, in_ready}, 32'd1);

      run("add_after_rst", 32'h0000_0020, 32'h0000_5A5A, 32'h0, 32'h0, 32'h0, -1, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 32'h0000_5A5A, 0, 0, 1);

      repeat (3) @(negedge CLK);
      chk("out_queue_drained", oq.size(), 32'd0);
      chk("mem_queue_drained", mq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
